cordic_share_ctrl: RTL and testbench

Round-robin scheduler that shares one pipelined CORDIC sine/cosine datapath among several requesters. It accepts phase requests, issues at most one per cycle into the pipeline, and tracks each in-flight operation with a requester tag in a shift register matched to the pipeline latency. It then steers each returning cos/sin pair to the requester that issued it. The block sits between the requesting engines and the CORDIC pipeline front end, and consumes the pipeline's final registered cos/sin outputs.

---
 rtl/cordic_share_ctrl.sv | 89 ++++++++
 tb/tb_cordic_share_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_share_ctrl.sv
// cordic_share_ctrl: round-robin sharing of one pipelined CORDIC among NREQ requesters with tag-based result steering
module cordic_share_ctrl #(
  parameter int NREQ = 4,
  parameter int PHASE_W = 16,
  parameter int PIPE_LAT = 19,
  parameter int MAX_OUT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*PHASE_W-1:0] req_phase,
  output logic [NREQ-1:0]         req_ready,
  output logic                    cd_valid,
  output logic [PHASE_W-1:0]      cd_phase,
  input  logic signed [15:0]      cd_cos,
  input  logic signed [15:0]      cd_sin,
  output logic [NREQ-1:0]         rsp_valid,
  output logic signed [15:0]      rsp_cos,
  output logic signed [15:0]      rsp_sin,
  output logic                    busy
);
  localparam int IDW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_OUT);
  localparam logic [IDW:0] NQ = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST = IDW'(NREQ - 1);
  logic [IDW-1:0]     r_rr;
  logic [CW-1:0]      r_out [NREQ];
  logic [PIPE_LAT:0]  r_tv;
  logic [IDW-1:0]     r_tid [PIPE_LAT+1];
  logic [NREQ-1:0]    w_elig, w_rot, w_ret_oh;
  logic [IDW:0]       w_off, w_sum;
  logic [IDW-1:0]     w_gid;
  logic               w_acc;
  logic [PHASE_W-1:0] w_phase;
  // a requester competes only while it still has credit left
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NREQ; i++) w_elig[i] = req_valid[i] && r_out[i] < MAXC;
  end
  assign w_rot = NREQ'({w_elig, w_elig} >> r_rr);
  // lowest set bit of the rotated vector is the first eligible index at or after the pointer
  always_comb begin
    w_off = '0;
    for (int k = NREQ - 1; k >= 0; k--) if (w_rot[k]) w_off = (IDW+1)'(k);
  end
  assign w_sum = w_off + {1'b0, r_rr};
  assign w_gid = w_sum >= NQ ? IDW'(w_sum - NQ) : w_sum[IDW-1:0];
  assign w_acc = |w_elig && !rst;
  assign req_ready = w_acc ? NREQ'(1) << w_gid : '0;
  assign w_ret_oh = r_tv[PIPE_LAT] ? NREQ'(1) << r_tid[PIPE_LAT] : '0;
  assign busy = |r_tv || |rsp_valid;
  // select the granted requester's phase
  always_comb begin
    w_phase = '0;
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) w_phase = req_phase[i*PHASE_W +: PHASE_W];
  end
  // tag shift register tracks who owns each pipeline slot; only the valid bits need clearing
  always_ff @(posedge clk) begin
    r_tv <= rst ? '0 : {r_tv[PIPE_LAT-1:0], w_acc};
    r_tid[0] <= w_gid;
    for (int k = 1; k <= PIPE_LAT; k++) r_tid[k] <= r_tid[k-1];
  end
  // per-requester in-flight counters: +1 on accept, -1 on return, both cancel
  always_ff @(posedge clk)
    for (int i = 0; i < NREQ; i++) r_out[i] <= rst ? '0 : r_out[i] + CW'(req_ready[i]) - CW'(w_ret_oh[i]);
  // issue to the pipeline, advance the pointer, and register returning results
  always_ff @(posedge clk) begin
    if (rst) begin
      cd_valid  <= 1'b0;
      cd_phase  <= '0;
      r_rr      <= '0;
      rsp_valid <= '0;
      rsp_cos   <= '0;
      rsp_sin   <= '0;
    end else begin
      cd_valid  <= w_acc;
      rsp_valid <= w_ret_oh;
      if (w_acc) begin
        cd_phase <= w_phase;
        r_rr     <= w_gid == LAST ? '0 : w_gid + 1'b1;
      end
      if (r_tv[PIPE_LAT]) begin
        rsp_cos <= cd_cos;
        rsp_sin <= cd_sin;
      end
    end
  end
endmodule

// File: tb/tb_cordic_share_ctrl.sv
// tb_cordic_share_ctrl: directed and randomized checking of cordic_share_ctrl against a queue-based model
module tb_cordic_share_ctrl;
  localparam int NREQ = 4;
  localparam int PW = 16;
  localparam int PIPE_LAT = 19;
  localparam int MAX_OUT = 4;
  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0] req_valid, req_ready, rsp_valid;
  logic [NREQ*PW-1:0] req_phase;
  logic cd_valid, busy;
  logic [PW-1:0] cd_phase;
  logic [15:0] cd_cos, cd_sin, rsp_cos, rsp_sin;
  logic [PW-1:0] pipe [PIPE_LAT];
  int checks = 0;
  int failures = 0;
  bit started = 1'b0;
  typedef struct { int id; logic [PW-1:0] ph; int due; } ent_t;
  ent_t q[$];
  int rr = 0;
  int edge_n = 0;
  logic m_cd_valid = 1'b0;
  logic [PW-1:0] m_cd_phase = '0;
  logic [NREQ-1:0] m_rsp_valid = '0;
  logic [15:0] m_cos = '0;
  logic [15:0] m_sin = '0;

  always #5 clk = ~clk;

  cordic_share_ctrl #(.NREQ(NREQ), .PHASE_W(PW), .PIPE_LAT(PIPE_LAT), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_phase(req_phase), .req_ready(req_ready),
    .cd_valid(cd_valid), .cd_phase(cd_phase), .cd_cos(cd_cos), .cd_sin(cd_sin),
    .rsp_valid(rsp_valid), .rsp_cos(rsp_cos), .rsp_sin(rsp_sin), .busy(busy));

  function automatic logic [15:0] f_cos(input logic [15:0] p);
    return p == 16'h2000 ? 16'h5A82 : p ^ 16'hC3A5;
  endfunction
  function automatic logic [15:0] f_sin(input logic [15:0] p);
    return p == 16'h2000 ? 16'h5A82 : {p[7:0], p[15:8]} + 16'h0101;
  endfunction

  // stand-in CORDIC: cd_cos/cd_sin hold f(phase) PIPE_LAT edges after cd_phase took that phase
  always @(posedge clk) begin
    pipe[0] <= cd_phase;
    for (int k = 1; k < PIPE_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign cd_cos = f_cos(pipe[PIPE_LAT-1]);
  assign cd_sin = f_sin(pipe[PIPE_LAT-1]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cnt(input int id);
    int n = 0;
    foreach (q[k]) if (q[k].id == id) n++;
    return n;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      int idx = (rr + k) % NREQ;
      logic [NREQ-1:0] s = v >> idx;
      if (s[0] && cnt(idx) < MAX_OUT) return idx;
    end
    return -1;
  endfunction

  // reference model: compare current outputs, then compute the effect of the coming edge
  always @(negedge clk) if (started) begin
    int g;
    logic [NREQ-1:0] exp_rdy;
    ent_t e;
    g = rst ? -1 : pick(req_valid);
    exp_rdy = g < 0 ? '0 : NREQ'(1) << g;
    chk("req_ready", req_ready, exp_rdy);
    chk("cd_valid", cd_valid, m_cd_valid);
    chk("cd_phase", cd_phase, m_cd_phase);
    chk("rsp_valid", rsp_valid, m_rsp_valid);
    chk("rsp_cos", rsp_cos, m_cos);
    chk("rsp_sin", rsp_sin, m_sin);
    chk("busy", busy, q.size() != 0 || m_rsp_valid != 0);
    edge_n++;
    if (rst) begin
      q.delete();
      rr = 0;
      m_cd_valid = 1'b0;
      m_cd_phase = '0;
      m_rsp_valid = '0;
      m_cos = '0;
      m_sin = '0;
    end else begin
      m_rsp_valid = '0;
      if (q.size() != 0 && q[0].due == edge_n) begin
        e = q.pop_front();
        m_rsp_valid = NREQ'(1) << e.id;
        m_cos = f_cos(e.ph);
        m_sin = f_sin(e.ph);
      end
      m_cd_valid = g >= 0;
      if (g >= 0) begin
        m_cd_phase = PW'(req_phase >> (g * PW));
        rr = (g + 1) % NREQ;
        q.push_back('{g, m_cd_phase, edge_n + PIPE_LAT + 1});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ph(input int i, input logic [PW-1:0] v);
    logic [NREQ*PW-1:0] m;
    m = {{(NREQ*PW-PW){1'b0}}, {PW{1'b1}}} << (i * PW);
    req_phase = (req_phase & ~m) | ((NREQ*PW)'(v) << (i * PW));
  endtask

  task automatic wait_idle();
    int n = 0;
    req_valid = '0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  initial begin
    logic [NREQ-1:0] g;
    rst = 1'b1;
    req_valid = '1;
    req_phase = '0;
    for (int i = 0; i < NREQ; i++) set_ph(i, 16'($urandom));
    @(posedge clk);
    started = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_cd_valid", cd_valid, 0);
    chk("rst_cd_phase", cd_phase, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_cos", rsp_cos, 0);
    chk("rst_rsp_sin", rsp_sin, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    rst = 1'b0;
    #1;
    chk("first_grant", req_ready, 4'b0001);
    for (int c = 0; c < 22; c++) begin
      chk("rr_order", req_ready, c < 16 ? 4'(1 << (c % 4)) : (c < 21 ? 4'b0000 : 4'b0001));
      if (c == 21) chk("rr_resp", rsp_valid, 4'b0001);
      g = req_ready;
      tick();
      for (int i = 0; i < NREQ; i++) if (g[i]) set_ph(i, 16'($urandom));
      #1;
    end
    wait_idle();
    req_valid = 4'b0100;
    set_ph(2, 16'h2000);
    #1;
    chk("single_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    chk("single_cd_valid", cd_valid, 1);
    chk("single_cd_phase", cd_phase, 16'h2000);
    repeat (19) tick();
    chk("single_early", rsp_valid, 0);
    tick();
    chk("single_rsp", rsp_valid, 4'b0100);
    chk("single_cos", rsp_cos, 16'h5A82);
    chk("single_sin", rsp_sin, 16'h5A82);
    chk("single_busy", busy, 1);
    tick();
    chk("single_busy_fall", busy, 0);
    chk("single_rsp_fall", rsp_valid, 0);
    req_valid = 4'b0010;
    #1;
    for (int c = 0; c < 22; c++) begin
      chk("credit_ready", req_ready, (c < 4 || c == 21) ? 4'b0010 : 4'b0000);
      if (c == 21) chk("credit_resp", rsp_valid, 4'b0010);
      g = req_ready;
      tick();
      if (g[1]) set_ph(1, 16'($urandom));
      #1;
    end
    wait_idle();
    req_valid = 4'b1000;
    set_ph(3, 16'h1000);
    #1;
    chk("route_g0", req_ready, 4'b1000);
    tick();
    req_valid = 4'b0001;
    set_ph(0, 16'h4000);
    #1;
    chk("route_g1", req_ready, 4'b0001);
    tick();
    req_valid = 4'b1000;
    set_ph(3, 16'h7000);
    #1;
    chk("route_g2", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    repeat (17) tick();
    chk("route_early", rsp_valid, 0);
    tick();
    chk("route_v0", rsp_valid, 4'b1000);
    chk("route_c0", rsp_cos, 16'hD3A5);
    chk("route_s0", rsp_sin, 16'h0111);
    tick();
    chk("route_v1", rsp_valid, 4'b0001);
    chk("route_c1", rsp_cos, 16'h83A5);
    chk("route_s1", rsp_sin, 16'h0141);
    tick();
    chk("route_v2", rsp_valid, 4'b1000);
    chk("route_c2", rsp_cos, 16'hB3A5);
    chk("route_s2", rsp_sin, 16'h0171);
    wait_idle();
    for (int c = 0; c < 400; c++) begin
      req_valid = (c % 100) < 50 ? 4'($urandom) | 4'($urandom) : 4'($urandom);
      for (int i = 0; i < NREQ; i++) if ($urandom_range(0, 3) == 0) set_ph(i, 16'($urandom));
      tick();
    end
    wait_idle();
    req_valid = 4'b0001;
    repeat (3) tick();
    req_valid = '0;
    repeat (10) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    for (int c = 0; c < 30; c++) begin
      chk("midrst_no_rsp", rsp_valid, 0);
      tick();
    end
    req_valid = 4'b0001;
    #1;
    for (int c = 0; c < 4; c++) begin
      chk("midrst_credit", req_ready, 4'b0001);
      tick();
      #1;
    end
    wait_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
